decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpudefs.sv | 29 ++
 rtl/decode_stage_pkg.sv | 34 +++
 rtl/decode_stage_if.sv | 46 ++++
 rtl/imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/cpudefs.sv
// cpudefs -- RV32I constants shared by the decode stage and the ALU.
//   ALUOP_*  : 3-bit ALU operation codes (AluOpAlt selects SUB / SRA).
//   OPC_*    : 7-bit major opcodes handled by the decoder.
//   FUNCT7_* : funct7 values accepted for OP / shift-immediate instructions.
package cpudefs;

   localparam logic [2:0] ALUOP_ADD  = 3'b000;
   localparam logic [2:0] ALUOP_SLL  = 3'b001;
   localparam logic [2:0] ALUOP_SLT  = 3'b010;
   localparam logic [2:0] ALUOP_SLTU = 3'b011;
   localparam logic [2:0] ALUOP_XOR  = 3'b100;
   localparam logic [2:0] ALUOP_SRL  = 3'b101;
   localparam logic [2:0] ALUOP_OR   = 3'b110;
   localparam logic [2:0] ALUOP_AND  = 3'b111;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

endpackage

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg -- types used inside the decode stage.
//   imm_fmt_e       : immediate format selector fed to imm_gen.
//   decode_bundle_t : the registered decoded bundle presented to execute.
package decode_stage_pkg;

   typedef enum logic [2:0] {
      ImmNone,
      ImmI,
      ImmShamt,
      ImmS,
      ImmB,
      ImmU,
      ImmJ
   } imm_fmt_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  alu_op;
      logic        alu_op_alt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] immediate;
      logic        use_immediate;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic [2:0]  branch_cond;
      logic        illegal;
   } decode_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if -- fetch-side and execute-side signals of the decode stage.
//   slave  : view of the decode stage (samples i_*, drives o_*).
//   master : view of the surrounding pipeline (drives i_*, samples o_*).
// Fetch side : i_InValid, o_InReady, i_Instruction, i_PC, i_Flush.
// Execute side: o_OutValid, i_OutReady and the decoded bundle o_*.
interface decode_stage_if;

   logic        i_InValid;
   logic        o_InReady;
   logic [31:0] i_Instruction;
   logic [31:0] i_PC;
   logic        i_Flush;

   logic        o_OutValid;
   logic        i_OutReady;
   logic [31:0] o_PC;
   logic [2:0]  o_AluOp;
   logic        o_AluOpAlt;
   logic [4:0]  o_Rs1;
   logic [4:0]  o_Rs2;
   logic [4:0]  o_Rd;
   logic [31:0] o_Immediate;
   logic        o_UseImmediate;
   logic        o_RegWrite;
   logic        o_MemRead;
   logic        o_MemWrite;
   logic        o_Branch;
   logic        o_Jump;
   logic [2:0]  o_BranchCond;
   logic        o_Illegal;

   modport slave (
      input  i_InValid, i_Instruction, i_PC, i_Flush, i_OutReady,
      output o_InReady, o_OutValid, o_PC, o_AluOp, o_AluOpAlt, o_Rs1, o_Rs2, o_Rd,
             o_Immediate, o_UseImmediate, o_RegWrite, o_MemRead, o_MemWrite, o_Branch,
             o_Jump, o_BranchCond, o_Illegal
   );

   modport master (
      output i_InValid, i_Instruction, i_PC, i_Flush, i_OutReady,
      input  o_InReady, o_OutValid, o_PC, o_AluOp, o_AluOpAlt, o_Rs1, o_Rs2, o_Rd,
             o_Immediate, o_UseImmediate, o_RegWrite, o_MemRead, o_MemWrite, o_Branch,
             o_Jump, o_BranchCond, o_Illegal
   );

endinterface

// File: rtl/imm_gen.sv
// imm_gen -- combinational RV32I immediate extraction.
//   i_Instruction : 32-bit instruction word.
//   i_Format      : immediate format (ImmNone yields zero).
//   o_Immediate   : sign-extended 32-bit immediate (shamt is zero-extended).
module imm_gen
   import decode_stage_pkg::*;
(
   input  logic [31:0] i_Instruction,
   input  imm_fmt_e    i_Format,
   output logic [31:0] o_Immediate
);

   // Opcode bits never carry immediate data.
   logic w_unused;
   assign w_unused = ^i_Instruction[6:0];

   always_comb begin
      o_Immediate = '0;
      case (i_Format)
         ImmI:     o_Immediate = {{20{i_Instruction[31]}}, i_Instruction[31:20]};
         ImmShamt: o_Immediate = {27'b0, i_Instruction[24:20]};
         ImmS:     o_Immediate = {{20{i_Instruction[31]}}, i_Instruction[31:25],
                                  i_Instruction[11:7]};
         ImmB:     o_Immediate = {{19{i_Instruction[31]}}, i_Instruction[31], i_Instruction[7],
                                  i_Instruction[30:25], i_Instruction[11:8], 1'b0};
         ImmU:     o_Immediate = {i_Instruction[31:12], 12'b0};
         ImmJ:     o_Immediate = {{11{i_Instruction[31]}}, i_Instruction[31],
                                  i_Instruction[19:12], i_Instruction[20],
                                  i_Instruction[30:21], 1'b0};
         default:  o_Immediate = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- RV32I decode pipeline stage with valid/ready handshake.
//   i_Clock : clock, rising edge.
//   i_Reset : synchronous active-high reset; drops any held bundle.
//   io_Pipe : decode_stage_if.slave -- fetch input handshake, flush, and the
//             registered decoded bundle with its output handshake.
// Latency is one cycle; accept and consume in the same cycle give full throughput.
module decode_stage
   import cpudefs::*;
   import decode_stage_pkg::*;
(
   input  logic          i_Clock,
   input  logic          i_Reset,
   decode_stage_if.slave io_Pipe
);

   logic           r_OutValid;
   decode_bundle_t r_Bundle;

   logic           w_InReady;
   logic           w_Accept;
   logic [6:0]     w_Opcode;
   logic [2:0]     w_Funct3;
   logic [6:0]     w_Funct7;
   logic           w_Illegal;
   imm_fmt_e       w_Format;
   logic [31:0]    w_Imm;
   decode_bundle_t w_Ctrl;
   decode_bundle_t w_Decoded;

   assign w_InReady = !r_OutValid || io_Pipe.i_OutReady;
   // Flush is not folded in here; it wins by priority in the register process.
   assign w_Accept  = io_Pipe.i_InValid && w_InReady;

   assign w_Opcode  = io_Pipe.i_Instruction[6:0];
   assign w_Funct3  = io_Pipe.i_Instruction[14:12];
   assign w_Funct7  = io_Pipe.i_Instruction[31:25];

   imm_gen u_imm_gen (
      .i_Instruction (io_Pipe.i_Instruction),
      .i_Format      (w_Format),
      .o_Immediate   (w_Imm)
   );

   always_comb begin
      w_Ctrl        = '0;
      w_Format      = ImmNone;
      w_Illegal     = 1'b0;
      w_Ctrl.pc     = io_Pipe.i_PC;
      w_Ctrl.rs1    = io_Pipe.i_Instruction[19:15];
      w_Ctrl.rs2    = io_Pipe.i_Instruction[24:20];
      w_Ctrl.rd     = io_Pipe.i_Instruction[11:7];
      w_Ctrl.alu_op = ALUOP_ADD;
      case (w_Opcode)
         OPC_OP_IMM: begin
            w_Ctrl.alu_op        = w_Funct3;
            w_Ctrl.use_immediate = 1'b1;
            w_Ctrl.reg_write     = 1'b1;
            if (w_Funct3 == ALUOP_SLL) begin
               w_Format  = ImmShamt;
               w_Illegal = (w_Funct7 != FUNCT7_BASE);
            end else if (w_Funct3 == ALUOP_SRL) begin
               w_Format          = ImmShamt;
               w_Ctrl.alu_op_alt = io_Pipe.i_Instruction[30];
               w_Illegal         = (w_Funct7 != FUNCT7_BASE) && (w_Funct7 != FUNCT7_ALT);
            end else begin
               w_Format = ImmI;
            end
         end
         OPC_OP: begin
            w_Ctrl.alu_op    = w_Funct3;
            w_Ctrl.reg_write = 1'b1;
            if ((w_Funct3 == ALUOP_ADD) || (w_Funct3 == ALUOP_SRL)) begin
               w_Ctrl.alu_op_alt = io_Pipe.i_Instruction[30];
               w_Illegal         = (w_Funct7 != FUNCT7_BASE) && (w_Funct7 != FUNCT7_ALT);
            end else begin
               w_Illegal = (w_Funct7 != FUNCT7_BASE);
            end
         end
         OPC_LOAD: begin
            w_Format             = ImmI;
            w_Ctrl.use_immediate = 1'b1;
            w_Ctrl.mem_read      = 1'b1;
            w_Ctrl.reg_write     = 1'b1;
         end
         OPC_STORE: begin
            w_Format             = ImmS;
            w_Ctrl.use_immediate = 1'b1;
            w_Ctrl.mem_write     = 1'b1;
         end
         OPC_BRANCH: begin
            w_Format           = ImmB;
            w_Ctrl.branch      = 1'b1;
            w_Ctrl.branch_cond = w_Funct3;
            case (w_Funct3)
               3'b000, 3'b001: w_Ctrl.alu_op_alt = 1'b1;
               3'b100, 3'b101: w_Ctrl.alu_op     = ALUOP_SLT;
               3'b110, 3'b111: w_Ctrl.alu_op     = ALUOP_SLTU;
               default:        w_Illegal         = 1'b1;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            w_Format             = ImmU;
            w_Ctrl.use_immediate = 1'b1;
            w_Ctrl.reg_write     = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            w_Format             = (w_Opcode == OPC_JAL) ? ImmJ : ImmI;
            w_Ctrl.use_immediate = 1'b1;
            w_Ctrl.reg_write     = 1'b1;
            w_Ctrl.jump          = 1'b1;
         end
         default: w_Illegal = 1'b1;
      endcase
      if (io_Pipe.i_Instruction[1:0] != 2'b11) begin
         w_Illegal = 1'b1;
      end
      // An illegal instruction must have no architectural side effects.
      if (w_Illegal) begin
         w_Ctrl.reg_write = 1'b0;
         w_Ctrl.mem_read  = 1'b0;
         w_Ctrl.mem_write = 1'b0;
         w_Ctrl.branch    = 1'b0;
         w_Ctrl.jump      = 1'b0;
      end
      if (w_Ctrl.rd == 5'd0) begin
         w_Ctrl.reg_write = 1'b0;
      end
      w_Ctrl.illegal = w_Illegal;
   end

   // Kept separate from the decoder so the format -> imm_gen -> bundle path is not a loop.
   always_comb begin
      w_Decoded           = w_Ctrl;
      w_Decoded.immediate = w_Imm;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_OutValid <= 1'b0;
         r_Bundle   <= '0;
      end else if (io_Pipe.i_Flush) begin
         r_OutValid <= 1'b0;
      end else if (w_Accept) begin
         r_OutValid <= 1'b1;
         r_Bundle   <= w_Decoded;
      end else if (io_Pipe.i_OutReady) begin
         r_OutValid <= 1'b0;
      end
   end

   assign io_Pipe.o_InReady      = w_InReady;
   assign io_Pipe.o_OutValid     = r_OutValid;
   assign io_Pipe.o_PC           = r_Bundle.pc;
   assign io_Pipe.o_AluOp        = r_Bundle.alu_op;
   assign io_Pipe.o_AluOpAlt     = r_Bundle.alu_op_alt;
   assign io_Pipe.o_Rs1          = r_Bundle.rs1;
   assign io_Pipe.o_Rs2          = r_Bundle.rs2;
   assign io_Pipe.o_Rd           = r_Bundle.rd;
   assign io_Pipe.o_Immediate    = r_Bundle.immediate;
   assign io_Pipe.o_UseImmediate = r_Bundle.use_immediate;
   assign io_Pipe.o_RegWrite     = r_Bundle.reg_write;
   assign io_Pipe.o_MemRead      = r_Bundle.mem_read;
   assign io_Pipe.o_MemWrite     = r_Bundle.mem_write;
   assign io_Pipe.o_Branch       = r_Bundle.branch;
   assign io_Pipe.o_Jump         = r_Bundle.jump;
   assign io_Pipe.o_BranchCond   = r_Bundle.branch_cond;
   assign io_Pipe.o_Illegal      = r_Bundle.illegal;

endmodule
